mult_div_unit: RTL

Parametrised multiply/divide unit for the MIPS pipeline, the successor to the single-cycle ALU. It sits beside the ALU in the EX stage and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO into architectural HI/LO registers. Multiply and divide have configurable latency with a `busy` flag, and the hazard unit stalls any HI/LO access while `busy` is high.

---
 rtl/md_pkg.sv | 16 +
 rtl/md_div_core.sv | 33 +++
 rtl/mult_div_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Op encodings and FSM state shared by the multiply/divide unit, controller and hazard unit.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// Combinational signed/unsigned divider: truncating quotient, remainder signed like the dividend.
module md_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b, uq, ur;

  always_comb begin
    neg_a = is_signed & a[WIDTH-1];
    neg_b = is_signed & b[WIDTH-1];
    abs_a = neg_a ? -a : a;
    abs_b = neg_b ? -b : b;
    uq    = '0;
    ur    = '0;
    quot  = '1;
    rem   = a;
    if (b != '0) begin
      uq   = abs_a / abs_b;
      ur   = abs_a % abs_b;
      // Most-negative / -1 falls out naturally: the magnitude wraps back to a, remainder 0.
      quot = (neg_a ^ neg_b) ? -uq : uq;
      rem  = neg_a ? -ur : ur;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: results are computed at accept, held pending, and
// committed to HI/LO only after the configured latency expires.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_state_e          state_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] pend_q;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0]   quot, rem;
  logic               mul_signed;

  always_comb begin
    mul_signed = (op == MD_MULT);
    ext_a      = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    ext_b      = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    // Low 2*WIDTH bits of the extended product are the exact signed/unsigned product.
    prod       = ext_a * ext_b;
  end

  md_div_core #(
    .WIDTH (WIDTH)
  ) u_div_core (
    .is_signed (op == MD_DIV),
    .a         (a),
    .b         (b),
    .quot      (quot),
    .rem       (rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU: begin
                pend_q  <= prod;
                cnt_q   <= CntW'(MULT_CYCLES);
                state_q <= StRun;
              end
              MD_DIV, MD_DIVU: begin
                pend_q  <= {rem, quot};
                cnt_q   <= CntW'(DIV_CYCLES);
                state_q <= StRun;
              end
              MD_MTHI: hi <= a;
              MD_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        StRun: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_q <= StIdle;
            hi      <= pend_q[2*WIDTH-1:WIDTH];
            lo      <= pend_q[WIDTH-1:0];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StRun);

endmodule
